transition_scan_ctrl: RTL and testbench
=======================================

Name: transition_scan_ctrl

Overview:
- Sequencer that drives counterUnit's 3-bit instruction bus to count 0->1 transitions in a captured data word.
- Accepts a word on a start pulse, issues a load instruction (100), then walks adjacent bit pairs LSB-first, issuing 001 per 0->1 transition and 000 otherwise.
- Latches the counter's result and pulses done.
- Sits between the stimulus/host logic and counterUnit in the transition-counting datapath.

Parameters:
- W, 8, data word width in bits (must be >= 2).
- nBits, 4, counter/result width; matches counterUnit nBits.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request to scan data_in; sampled only in IDLE.
- data_in  input  W  word to scan; captured on the accepting edge.
- count_in  input  nBits  result from counterUnit.
- instruction  output  3  instruction to counterUnit (100 load, 001 transition, 000 idle).
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when result is valid.
- result  output  nBits  latched transition count; holds until next done.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, data register=0, index=0, instruction=000, busy=0, done=0, result=0. Applies mid-scan as well; the scan is abandoned with no done pulse.
- counterUnit reset is active-high; the top level drives it with ~reset.
- FSM states: IDLE, LOAD, SCAN, DONE. The instruction output is decoded from the registered state and data (Moore), so the counter samples it at the next edge.
- IDLE:
  - instruction=000, busy=0.
  - start=1: capture data_in, go to LOAD. start=0: stay.
- LOAD:
  - instruction=100, busy=1.
  - Next: SCAN with index=1.
- SCAN:
  - busy=1. instruction=001 if data[index-1]==0 && data[index]==1, else 000.
  - index < W-1: index+1, stay. index == W-1: go to DONE.
- DONE:
  - instruction=000, busy=1. count_in already reflects all increments.
  - On the next edge: result<=count_in, done<=1, go to IDLE.
- done is registered and high for exactly the one IDLE cycle after DONE. It is cleared on the following edge unless a new scan completes.
- Latency: accepting edge at t0 -> LOAD at t0+1 -> SCAN W-1 cycles -> DONE -> done high W+2 cycles after t0.
- start while busy=1 is ignored, not queued. A start during the done cycle (state IDLE) is accepted; done still deasserts on the next edge.
- data_in changes after capture have no effect on the scan in progress.
- Arithmetic:
  - index width is clog2(W)+1. No overflow checking in the controller.
  - The counter wraps modulo 2^nBits. W <= 2*(2^nBits-1) guarantees no wrap.

Optional Feature:
- Macro CIRCULAR_SCAN_EN.
- Defined: after the SCAN step with index=W-1, one extra SCAN step compares data[W-1]==0 && data[0]==1 (wrap pair) and issues 001/000 accordingly. Then DONE. Total latency W+3 cycles.
- Undefined: wrap pair not examined. Latency W+2 cycles, as above.

Test Plan:
- Reset low mid-SCAN (W=8, 8'h55, third SCAN cycle) -> instruction=000, busy=0, done=0, result=0 immediately. After release: IDLE, no done pulse until a new start.
- start with data_in=8'b0101_0101 (W=8, nBits=4) -> instruction sequence 100, then 000,001,000,001,000,001,000.
  - done one cycle, 10 cycles after accept, with result=3.
  - With CIRCULAR_SCAN_EN: extra 001, result=4, done at 11 cycles.
- data_in=8'b1111_0000 -> single 001 at index=4, result=1 (also 1 with CIRCULAR_SCAN_EN).
- data_in=8'h00 and 8'hFF -> no 001 issued, result=0. The previous result is held until the new done, then overwritten to 0.
- start pulsed every cycle during a scan, data_in toggling -> only the first start accepted, result from the first captured word. A start during the done cycle begins the next scan: LOAD on the following cycle.
- Back-to-back scans 8'h55 then 8'h0F -> second LOAD (100) clears the counter. Results are 3 then 0 (8'h0F: bits 0-3=1, 4-7=0, no 0->1).

Source files
------------

// File: rtl/transition_scan_ctrl_if.sv
// Bundled host/counter-side signals of transition_scan_ctrl.
// master = stimulus/counter side, slave = the controller itself.
interface transition_scan_ctrl_if #(
  parameter int W     = 8,
  parameter int nBits = 4
);
  logic             start;
  logic [W-1:0]     data_in;
  logic [nBits-1:0] count_in;
  logic [2:0]       instruction;
  logic             busy;
  logic             done;
  logic [nBits-1:0] result;

  modport master (
    output start, data_in, count_in,
    input  instruction, busy, done, result
  );

  modport slave (
    input  start, data_in, count_in,
    output instruction, busy, done, result
  );
endinterface

// File: rtl/transition_scan_ctrl.sv
// Sequences counterUnit to count 0->1 transitions in a captured word, LSB first.
// Define CIRCULAR_SCAN_EN to also examine the wrap pair data[W-1] -> data[0].
module transition_scan_ctrl #(
  parameter int W     = 8,
  parameter int nBits = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  transition_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(W) + 1;
`ifdef CIRCULAR_SCAN_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(W);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_data;
  logic [IW-1:0]    r_index;
  logic [nBits-1:0] r_result;
  logic             r_done;
  logic [2:0]       w_instruction;
  logic             w_busy;
  logic [W-1:0]     w_pair_hit;
  logic             w_transition;

  // One detector per adjacent pair; r_index names the upper bit of the pair.
  genvar gi;
  generate
    for (gi = 0; gi < W - 1; gi++) begin : g_pair
      assign w_pair_hit[gi] = (r_index == IW'(gi + 1)) && !r_data[gi] && r_data[gi + 1];
    end
  endgenerate

`ifdef CIRCULAR_SCAN_EN
  assign w_pair_hit[W-1] = (r_index == IW'(W)) && !r_data[W-1] && r_data[0];
`else
  assign w_pair_hit[W-1] = 1'b0;
`endif

  assign w_transition = |w_pair_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_instruction = 3'b000;
    w_busy        = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_instruction = 3'b100;
        w_state_next  = SCAN;
      end
      SCAN: begin
        w_instruction = w_transition ? 3'b001 : 3'b000;
        if (r_index == LAST_IDX) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // The counter has absorbed the last SCAN instruction by the time DONE is seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data   <= '0;
      r_index  <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_data <= bus.data_in;
          end
        end
        LOAD: r_index  <= IW'(1);
        SCAN: r_index  <= r_index + IW'(1);
        DONE: r_result <= bus.count_in;
        default: ;
      endcase
    end
  end

  assign bus.instruction = w_instruction;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
endmodule

// File: tb/tb_transition_scan_ctrl.sv
// Scoreboard bench for transition_scan_ctrl with a behavioural counterUnit.
// Build with CIRCULAR_SCAN_EN defined to check the wrap-pair variant.
module tb_transition_scan_ctrl;
  localparam int W  = 8;
  localparam int NB = 4;

`ifdef CIRCULAR_SCAN_EN
  localparam int            LAT = W + 3;
  localparam logic [W:0]    M55 = 9'h154;
  localparam logic [NB-1:0] R55 = 4'd4;
  localparam logic [W:0]    M0F = 9'h100;
  localparam logic [NB-1:0] R0F = 4'd1;
`else
  localparam int            LAT = W + 2;
  localparam logic [W:0]    M55 = 9'h054;
  localparam logic [NB-1:0] R55 = 4'd3;
  localparam logic [W:0]    M0F = 9'h000;
  localparam logic [NB-1:0] R0F = 4'd0;
`endif
  localparam logic [W:0]    MF0 = 9'h010;
  localparam logic [NB-1:0] RF0 = 4'd1;

  typedef struct {
    logic [NB-1:0] res;
    logic [W:0]    mask;
    logic [W-1:0]  word;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  transition_scan_ctrl_if #(.W(W), .nBits(NB)) bus ();
  transition_scan_ctrl #(.W(W), .nBits(NB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // counterUnit: active-high reset driven from ~reset, 100 clears, 001 increments
  logic [NB-1:0] cnt_q;
  always_ff @(posedge clock or posedge (~reset)) begin
    if (~reset) begin
      cnt_q <= '0;
    end else if (bus.instruction == 3'b100) begin
      cnt_q <= '0;
    end else if (bus.instruction == 3'b001) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.count_in = cnt_q;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: rebuild the 001 positions after each LOAD and check against the queue on done.
  bit         in_scan   = 1'b0;
  bit         prev_done = 1'b0;
  int         pos       = 0;
  int         lat       = 0;
  logic [W:0] obs_mask  = '0;
  exp_t       mon_e;

  always @(negedge clock) begin
    if (!reset) begin
      in_scan   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
      end
      if (bus.instruction == 3'b100) begin
        in_scan  = 1'b1;
        pos      = 1;
        obs_mask = '0;
        lat      = 1;
      end else if (in_scan) begin
        lat++;
        if (bus.instruction == 3'b001) begin
          obs_mask = obs_mask | ((W + 1)'(1) << pos);
        end
        pos++;
      end
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result %0d with no scan pending", bus.result);
        end else begin
          mon_e = exp_q.pop_front();
          $display("scan word=%h result=%0d (exp %0d) mask=%h (exp %h) latency=%0d (exp %0d)",
                   mon_e.word, bus.result, mon_e.res, obs_mask, mon_e.mask, lat, LAT);
          check("result", {28'd0, bus.result}, {28'd0, mon_e.res});
          check("instr_mask", {23'd0, obs_mask}, {23'd0, mon_e.mask});
          check("latency", lat, LAT);
        end
        in_scan = 1'b0;
      end
      prev_done = bus.done;
    end
  end

  // Drive a start in the current cycle; returns one cycle later with start dropped.
  task automatic issue(input logic [W-1:0] word, input bit expect_it,
                       input logic [NB-1:0] r, input logic [W:0] m);
    bus.start   = 1'b1;
    bus.data_in = word;
    if (expect_it) exp_q.push_back('{res: r, mask: m, word: word});
    @(posedge clock); #1;
    bus.start   = 1'b0;
    bus.data_in = ~word;
  endtask

  // Returns in the done cycle (#1 after the edge) or reports a timeout.
  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_instr",  {29'd0, bus.instruction}, 32'd0);
    check("reset_busy",   {31'd0, bus.busy}, 32'd0);
    check("reset_done",   {31'd0, bus.done}, 32'd0);
    check("reset_result", {28'd0, bus.result}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    issue(8'h55, 1'b1, R55, M55);
    wait_done("s55");
    @(posedge clock); #1;
    issue(8'hF0, 1'b1, RF0, MF0);
    wait_done("sF0");

    @(posedge clock); #1;
    issue(8'h00, 1'b1, 4'd0, 9'h000);
    repeat (3) @(posedge clock);
    #1;
    check("hold_prev_result_1", {28'd0, bus.result}, {28'd0, RF0});
    wait_done("s00");

    @(posedge clock); #1;
    issue(8'h55, 1'b1, R55, M55);
    wait_done("s55b");
    @(posedge clock); #1;
    issue(8'hFF, 1'b1, 4'd0, 9'h000);
    repeat (3) @(posedge clock);
    #1;
    check("hold_prev_result_2", {28'd0, bus.result}, {28'd0, R55});
    wait_done("sFF");

    // back-to-back: start during the done cycle
    issue(8'h55, 1'b1, R55, M55);
    wait_done("b2b_first");
    issue(8'h0F, 1'b1, R0F, M0F);
    check("b2b_load", {29'd0, bus.instruction}, 32'h4);
    wait_done("b2b_second");

    // start held high with data_in toggling during a scan
    @(posedge clock); #1;
    bus.start   = 1'b1;
    bus.data_in = 8'h55;
    exp_q.push_back('{res: R55, mask: M55, word: 8'h55});
    for (int k = 1; k < LAT; k++) begin
      @(posedge clock); #1;
      bus.data_in = ~bus.data_in;
    end
    @(posedge clock); #1;
    check("spam_done", {31'd0, bus.done}, 32'd1);
    bus.data_in = 8'hF0;
    exp_q.push_back('{res: RF0, mask: MF0, word: 8'hF0});
    @(posedge clock); #1;
    check("spam_next_load", {29'd0, bus.instruction}, 32'h4);
    bus.start   = 1'b0;
    bus.data_in = 8'h00;
    wait_done("spam_second");

    // reset asserted in the third SCAN cycle; the scan is abandoned
    @(posedge clock); #1;
    issue(8'h55, 1'b0, 4'd0, 9'h000);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_instr",  {29'd0, bus.instruction}, 32'd0);
    check("midrst_busy",   {31'd0, bus.busy}, 32'd0);
    check("midrst_done",   {31'd0, bus.done}, 32'd0);
    check("midrst_result", {28'd0, bus.result}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    check("postrst_busy",   {31'd0, bus.busy}, 32'd0);
    check("postrst_result", {28'd0, bus.result}, 32'd0);

    issue(8'hF0, 1'b1, RF0, MF0);
    wait_done("recover");
    @(posedge clock); #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
